branch_pred_unit: RTL
=====================

# branch_pred_unit

Parametrised next-PC generator and branch resolution unit for the rv32i pipeline. It owns the fetch PC register. At fetch it predicts through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. In execute it resolves all six conditional branches plus JAL/JALR, detects mispredictions and misaligned targets, redirects fetch, raises the flush request and trains the BTB.

## Interface
- DPW, rv32i_pkg::DPW (32): datapath/PC width.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- TRAP_PC, 32'h0000_0004: redirect target on misaligned taken target.
- BTB_DEPTH, 16: BTB entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold fetch PC.
- pcf_o  out  DPW  current fetch PC, registered.
- pred_taken_f_o  out  1  prediction for pcf_o.
- pred_target_f_o  out  DPW  predicted target for pcf_o, or pcf_o+4 when not taken.
- ex_valid_i  in  1  execute-stage instruction valid.
- ex_kind_i  in  br_kind_t  BR_NONE / BR_COND / BR_JAL / BR_JALR.
- ex_funct3_i  in  3  branch condition for BR_COND.
- ex_pc_i  in  DPW  PC of the execute instruction.
- ex_rs1_i, ex_rs2_i  in  DPW  operands.
- ex_imm_i  in  DPW  sign-extended immediate.
- ex_pred_taken_i, ex_pred_target_i  in  1, DPW  prediction carried down the pipe.
- ex_link_o  out  DPW  ex_pc_i+4 (rd value for JAL/JALR).
- flush_o  out  1  squash the younger IF/ID instructions this cycle.
- misalign_o  out  1  misaligned-target trap pulse.

## Operation
- Index is pcf_o[IDX+1:2], where IDX = log2(BTB_DEPTH). Tag is pcf_o[DPW-1:IDX+2]. An entry holds valid, tag, target and ctr[1:0].
- Fetch prediction: hit = valid && tag match. pred_taken_f_o = hit && ctr[1].
- Resolution applies only when ex_valid_i is high and ex_kind_i is not BR_NONE.
  - Conditions by funct3: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. Funct3 010/011 resolve as not taken.
  - JAL and JALR are always taken.
  - Target for BR_COND and JAL: ex_pc_i + ex_imm_i, modulo 2^DPW.
  - Target for JALR: (ex_rs1_i + ex_imm_i) & ~1.
- Misaligned: taken and target[1] = 1. Result: misalign_o = 1, flush_o = 1, next PC = TRAP_PC, no BTB update.
- Mispredict: taken != ex_pred_taken_i, or taken && target != ex_pred_target_i. Result: flush_o = 1, next PC = target if taken, else ex_pc_i+4.
- BTB training, only when not misaligned:
  - Taken and hit: write target, increment ctr (saturates at 11).
  - Taken and miss: allocate with valid = 1, tag, target, ctr = 10.
  - Not taken and hit: decrement ctr (saturates at 00).
  - Not taken and miss: no change.
- Next-PC priority: rst_i, then misalign/mispredict redirect (overrides stall_i), then stall_i (hold), then pred_target_f_o.

## Timing
- Reset values: pcf_o = RESET_PC; all BTB valid bits = 0; ctr and target are don't-care.
- Reset is asynchronous and may assert mid-operation. Prediction outputs then read all-invalid, giving pred_target_f_o = RESET_PC+4.
- flush_o and misalign_o are combinational from execute inputs and are forced to 0 while rst_i is high. They are one cycle per event.
- Prediction outputs are combinational from pcf_o and BTB state.
- Redirect latency: the new PC appears on pcf_o one cycle after the resolving cycle.
- A BTB write at index i becomes visible from the next cycle. A same-cycle lookup of index i returns the old entry.
- Entries are aliased by index. A tag mismatch is a miss; a taken resolution overwrites the entry.

## Structure
- rv32i_pkg gains br_kind_t and br_cond_t (funct3 encodings). DPW stays there.
- One sub-module, branch_cmp: combinational condition evaluator (funct3, rs1, rs2 -> taken).
- The BTB arrays, PC register and next-PC mux live in branch_pred_unit.

## Test plan
- Reset: RESET_PC=0x100, run 3 cycles, assert rst_i asynchronously -> pcf_o = 0x100 immediately; a fetch of a previously trained PC gives pred_taken_f_o = 0.
- Stall: pcf_o 0x100, then 0x104; stall_i high for 2 cycles -> pcf_o stays 0x104, then 0x108.
- Cold BEQ: ex_pc 0x108, imm -8, rs1 = rs2 = 5, pred 0 -> flush_o = 1, next pcf_o = 0x100. Later fetch of 0x108 -> pred_taken 1, target 0x100, no flush on re-resolution.
- Signedness: rs1 = 0xFFFF_FFFF, rs2 = 1 -> BLT taken, BLTU not taken, BGEU taken.
- JALR: rs1 = 0x203, imm 0 -> target 0x202, misalign_o = 1, next pcf_o = TRAP_PC, BTB entry for ex_pc stays invalid. Also JALR rs1 = 0x301, imm 0 -> target 0x300, aligned, taken.
- Saturation and priority: 4 taken resolutions -> ctr 11; one not-taken -> still predicts taken, flush on that not-taken. Redirect with stall_i = 1 -> redirect wins.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared rv32i pipeline types: datapath width, branch kinds
//               and conditional-branch funct3 encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int DPW = 32;

  // Control-flow class of the instruction in execute
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } br_kind_t;

  // funct3 encodings of the conditional branches (010/011 are unused)
  typedef enum logic [2:0] {
    BC_BEQ  = 3'b000,
    BC_BNE  = 3'b001,
    BC_BLT  = 3'b100,
    BC_BGE  = 3'b101,
    BC_BLTU = 3'b110,
    BC_BGEU = 3'b111
  } br_cond_t;

endpackage
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// ============================================================================
// Module      : branch_cmp
// Description : Combinational conditional-branch evaluator (funct3, rs1, rs2
//               -> taken). Reserved funct3 values resolve as not taken.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cmp #(
  parameter int DPW = 32
) (
  input  logic [2:0]     i_funct3,
  input  logic [DPW-1:0] i_rs1,
  input  logic [DPW-1:0] i_rs2,
  output logic           o_taken
);
  import rv32i_pkg::*;

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_rs1 == i_rs2);
  assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
  assign w_lt_u = (i_rs1 < i_rs2);

  // Select the comparison result that matches the branch condition
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      BC_BEQ:  o_taken = w_eq;
      BC_BNE:  o_taken = !w_eq;
      BC_BLT:  o_taken = w_lt_s;
      BC_BGE:  o_taken = !w_lt_s;
      BC_BLTU: o_taken = w_lt_u;
      BC_BGEU: o_taken = !w_lt_u;
      default: o_taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_unit
// Description : Fetch PC owner with a direct-mapped BTB (2-bit counters) for
//               prediction, plus execute-stage branch resolution, redirect,
//               flush/misalign signalling and BTB training.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_unit #(
  parameter int             DPW       = rv32i_pkg::DPW,
  parameter logic [DPW-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [DPW-1:0] TRAP_PC   = 32'h0000_0004,
  parameter int             BTB_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  output logic [DPW-1:0]      pcf_o,
  output logic                pred_taken_f_o,
  output logic [DPW-1:0]      pred_target_f_o,
  input  logic                ex_valid_i,
  input  rv32i_pkg::br_kind_t ex_kind_i,
  input  logic [2:0]          ex_funct3_i,
  input  logic [DPW-1:0]      ex_pc_i,
  input  logic [DPW-1:0]      ex_rs1_i,
  input  logic [DPW-1:0]      ex_rs2_i,
  input  logic [DPW-1:0]      ex_imm_i,
  input  logic                ex_pred_taken_i,
  input  logic [DPW-1:0]      ex_pred_target_i,
  output logic [DPW-1:0]      ex_link_o,
  output logic                flush_o,
  output logic                misalign_o
);
  import rv32i_pkg::*;

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = DPW - IDX - 2;

  logic [DPW-1:0]       r_pcf;
  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag    [BTB_DEPTH];
  logic [DPW-1:0]       r_btb_target [BTB_DEPTH];
  logic [1:0]           r_btb_ctr    [BTB_DEPTH];

  logic [IDX-1:0]   w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX-1:0]   w_e_idx;
  logic [TAG_W-1:0] w_e_tag;
  logic             w_e_hit;
  logic             w_cond_taken;
  logic             w_resolve;
  logic             w_taken;
  logic [DPW-1:0]   w_target;
  logic             w_misalign;
  logic             w_mispredict;
  logic             w_train;
  logic [DPW-1:0]   w_next_pc;

  // Fetch-side lookup
  assign w_f_idx = r_pcf[IDX+1:2];
  assign w_f_tag = r_pcf[DPW-1:IDX+2];
  assign w_f_hit = r_btb_valid[w_f_idx] && (r_btb_tag[w_f_idx] == w_f_tag);

  assign pcf_o           = r_pcf;
  assign pred_taken_f_o  = w_f_hit && r_btb_ctr[w_f_idx][1];
  assign pred_target_f_o = pred_taken_f_o ? r_btb_target[w_f_idx] : (r_pcf + DPW'(4));

  // Execute-side lookup of the resolving branch's own entry
  assign w_e_idx = ex_pc_i[IDX+1:2];
  assign w_e_tag = ex_pc_i[DPW-1:IDX+2];
  assign w_e_hit = r_btb_valid[w_e_idx] && (r_btb_tag[w_e_idx] == w_e_tag);

  assign ex_link_o = ex_pc_i + DPW'(4);

  branch_cmp #(
    .DPW (DPW)
  ) u_branch_cmp (
    .i_funct3 (ex_funct3_i),
    .i_rs1    (ex_rs1_i),
    .i_rs2    (ex_rs2_i),
    .o_taken  (w_cond_taken)
  );

  // Resolve direction and target of the execute-stage control transfer
  always_comb begin
    w_resolve = ex_valid_i && (ex_kind_i != BR_NONE);
    w_taken   = 1'b0;
    w_target  = ex_pc_i + ex_imm_i;
    case (ex_kind_i)
      BR_COND: w_taken = w_cond_taken;
      BR_JAL:  w_taken = 1'b1;
      BR_JALR: begin
        w_taken  = 1'b1;
        w_target = (ex_rs1_i + ex_imm_i) & ~DPW'(1);
      end
      default: w_taken = 1'b0;
    endcase
  end

  // A misaligned taken target traps instead of being treated as a mispredict
  assign w_misalign   = w_resolve && w_taken && w_target[1];
  assign w_mispredict = w_resolve && !w_misalign &&
                        ((w_taken != ex_pred_taken_i) ||
                         (w_taken && (w_target != ex_pred_target_i)));
  assign w_train      = w_resolve && !w_misalign;

  assign misalign_o = !rst_i && w_misalign;
  assign flush_o    = !rst_i && (w_misalign || w_mispredict);

  // Next-PC priority: trap, mispredict redirect, stall hold, prediction
  always_comb begin
    w_next_pc = pred_target_f_o;
    if (w_misalign) begin
      w_next_pc = TRAP_PC;
    end else if (w_mispredict) begin
      w_next_pc = w_taken ? w_target : ex_link_o;
    end else if (stall_i) begin
      w_next_pc = r_pcf;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pcf <= RESET_PC;
    end else begin
      r_pcf <= w_next_pc;
    end
  end

  // BTB valid bits: set on taken allocation, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_btb_valid <= '0;
    end else if (w_train && w_taken) begin
      r_btb_valid[w_e_idx] <= 1'b1;
    end
  end

  // BTB payload (tag, target, counter) needs no reset; valid gates its use
  always_ff @(posedge clk_i) begin
    if (w_train) begin
      if (w_taken) begin
        r_btb_tag[w_e_idx]    <= w_e_tag;
        r_btb_target[w_e_idx] <= w_target;
        if (!w_e_hit) begin
          r_btb_ctr[w_e_idx] <= 2'b10;
        end else if (r_btb_ctr[w_e_idx] != 2'b11) begin
          r_btb_ctr[w_e_idx] <= r_btb_ctr[w_e_idx] + 2'b01;
        end
      end else if (w_e_hit && (r_btb_ctr[w_e_idx] != 2'b00)) begin
        r_btb_ctr[w_e_idx] <= r_btb_ctr[w_e_idx] - 2'b01;
      end
    end
  end

endmodule
`default_nettype wire
